// File: rtl/test_signal_gen.sv
// Test-signal source: programmable-period, programmable-duty pulse wave with a period-start tick.
// Optional macro SIG_PERIOD_COUNT_EN adds a 16-bit count of emitted period ticks.
`timescale 1ns/1ps

module test_signal_gen #(
   parameter int DIV_W   = 24,
   parameter int PRESET0 = 16000,
   parameter int PRESET1 = 8000,
   parameter int PRESET2 = 1000000,
   parameter int PRESET3 = 4000
) (
   input  logic             sysclk,
   input  logic             reset,
   input  logic             enable,
   input  logic [1:0]       testmode,
   input  logic             use_custom,
   input  logic [DIV_W-1:0] custom_div,
   input  logic [7:0]       duty,
   output logic             sigout,
   output logic             period_tick,
   output logic [DIV_W-1:0] act_period
`ifdef SIG_PERIOD_COUNT_EN
   ,
   output logic [15:0]      period_cnt
`endif
);

   localparam int PRESETS [4] = '{PRESET0, PRESET1, PRESET2, PRESET3};
   localparam logic [DIV_W-1:0] RST_PERIOD = DIV_W'(PRESET0);
   localparam logic [DIV_W-1:0] RST_HIGH   = DIV_W'((longint'(PRESET0) * 128) >>> 8);
   localparam logic [DIV_W-1:0] ONE        = DIV_W'(1);
   localparam logic [DIV_W-1:0] MIN_PERIOD = DIV_W'(2);

   logic [DIV_W-1:0] preset_tab [4];
   logic [DIV_W-1:0] p_sel;
   logic [DIV_W-1:0] p_in;
   logic [DIV_W+7:0] prod;
   logic [DIV_W-1:0] h_in;
   logic [DIV_W-1:0] cnt_reg;
   logic [DIV_W-1:0] cnt_inc;
   logic [DIV_W-1:0] act_high_reg;
   logic             wrap;

   genvar gi;
   generate
      for (gi = 0; gi < 4; gi++) begin : g_preset
         assign preset_tab[gi] = DIV_W'(PRESETS[gi]);
      end
   endgenerate

   // Candidate configuration, only latched at a period boundary or while disabled.
   always_comb begin
      p_sel = use_custom ? custom_div : preset_tab[testmode];
      p_in  = (p_sel < MIN_PERIOD) ? MIN_PERIOD : p_sel;
      prod  = (DIV_W+8)'(p_in) * (DIV_W+8)'(duty);
      h_in  = prod[DIV_W+7:8];
      // p_in is at least 2, so a non-zero product means a non-zero duty.
      if ((prod != '0) && (h_in == '0))
         h_in = ONE;
   end

   assign cnt_inc = cnt_reg + ONE;
   assign wrap    = (cnt_reg == (act_period - ONE));

   always_ff @(posedge sysclk) begin
      if (reset) begin
         cnt_reg      <= RST_PERIOD - ONE;
         act_period   <= RST_PERIOD;
         act_high_reg <= RST_HIGH;
         sigout       <= 1'b0;
         period_tick  <= 1'b0;
      end else if (!enable) begin
         // Preloading cnt to p_in-1 makes the first enabled cycle a wrap.
         cnt_reg      <= p_in - ONE;
         act_period   <= p_in;
         act_high_reg <= h_in;
         sigout       <= 1'b0;
         period_tick  <= 1'b0;
      end else if (wrap) begin
         cnt_reg      <= '0;
         act_period   <= p_in;
         act_high_reg <= h_in;
         sigout       <= (h_in != '0);
         period_tick  <= 1'b1;
      end else begin
         cnt_reg      <= cnt_inc;
         sigout       <= (cnt_inc < act_high_reg);
         period_tick  <= 1'b0;
      end
   end

`ifdef SIG_PERIOD_COUNT_EN
   // Counts in the same cycle period_tick is raised, so both outputs change together.
   always_ff @(posedge sysclk) begin
      if (reset)
         period_cnt <= 16'd0;
      else if (enable && wrap)
         period_cnt <= period_cnt + 16'd1;
   end
`endif

endmodule
